// File: rtl/key_replay_pkg.sv
// key_replay_pkg: shared state encoding and width helpers for key_replay
package key_replay_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    function automatic int cnt_w(input int h, input int g);
        return $clog2((h > g ? h : g) + 1);
    endfunction

    // A zero-depth queue still needs a one-bit port
    function automatic int pend_w(input int p);
        return p > 0 ? $clog2(p + 1) : 1;
    endfunction

endpackage

// File: rtl/key_replay.sv
// key_replay: turns one-cycle event pulses into fixed-length key-like highs
// separated by a guaranteed low gap, queueing events that arrive while busy.
module key_replay
    import key_replay_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_MAX    = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          In,
    output logic                          Out,
    output logic                          busy,
    output logic                          drop,
    output logic [pend_w(PEND_MAX)-1:0]   pending
);

    localparam int CW = cnt_w(HOLD_CYCLES, GAP_CYCLES);
    localparam int PW = pend_w(PEND_MAX);

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [PW-1:0]   r_pend, w_pend, w_base;
    logic            r_out, r_drop;
    logic            w_final, w_use, w_queue, w_acc, w_drop;

    always_comb begin
        w_final = r_state == GAP && r_cnt == '0;
        w_use   = w_final && r_pend != '0;
        // In during the final gap cycle with an empty queue starts HOLD directly
        w_queue = In && (r_state == HOLD || (r_state == GAP && !(w_final && r_pend == '0)));
        w_base  = r_pend - PW'(w_use);
        w_acc   = w_queue && w_base < PW'(PEND_MAX);
        w_pend  = w_base + PW'(w_acc);
        w_drop  = w_queue && !w_acc;
        w_state = r_state;
        w_cnt   = r_cnt;
        if (r_state == IDLE) begin
            if (In) begin
                w_state = HOLD;
                w_cnt   = CW'(HOLD_CYCLES - 1);
            end
        end else if (r_state == HOLD) begin
            w_state = r_cnt == '0 ? GAP : HOLD;
            w_cnt   = r_cnt == '0 ? CW'(GAP_CYCLES - 1) : r_cnt - 1'b1;
        end else if (r_cnt != '0) begin
            w_cnt = r_cnt - 1'b1;
        end else if (w_use || In) begin
            w_state = HOLD;
            w_cnt   = CW'(HOLD_CYCLES - 1);
        end else begin
            w_state = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_out   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_pend  <= w_pend;
            r_out   <= w_state == HOLD;
            r_drop  <= w_drop;
        end
    end

    assign Out     = r_out;
    assign busy    = r_state != IDLE;
    assign drop    = r_drop;
    assign pending = r_pend;

endmodule

// File: tb/tb_key_replay.sv
// tb_key_replay: table-driven directed checks plus reset and loopback sequences
module tb_key_replay;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       In = 1'b0;
    logic       Out, busy, drop;
    logic [1:0] pending;

    int checks = 0;
    int errors = 0;

    key_replay dut (
        .clock(clock), .reset(reset), .In(In),
        .Out(Out), .busy(busy), .drop(drop), .pending(pending)
    );

    always #5 clock = ~clock;

    // Downstream userInput model: 2-flop synchronizer plus rising-edge detector
    logic s1, s2, s3;
    int   lb_edges = 0;
    always @(posedge clock) begin
        if (reset) begin
            s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
        end else begin
            s1 <= Out; s2 <= s1; s3 <= s2;
            if (s2 && !s3) lb_edges <= lb_edges + 1;
        end
    end

    typedef struct {
        logic       in;
        logic       out;
        logic       busy;
        logic       drop;
        logic [1:0] pend;
    } vec_t;

    vec_t v[$];

    task automatic add(input logic i, input logic o, input logic b, input logic d, input logic [1:0] p);
        v.push_back('{i, o, b, d, p});
    endtask

    // One in=0 replay of a queued event: 4 high cycles then 2 gap cycles
    task automatic cyc(input logic [1:0] p);
        for (int i = 0; i < 4; i++) add(0, 1, 1, 0, p);
        for (int i = 0; i < 2; i++) add(0, 0, 1, 0, p);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic o, input logic b, input logic d, input logic [1:0] p);
        checks++;
        if ({Out, busy, drop, pending} !== {o, b, d, p}) begin
            errors++;
            $display("FAIL %s got out=%b busy=%b drop=%b pend=%0d want out=%b busy=%b drop=%b pend=%0d",
                     name, Out, busy, drop, pending, o, b, d, p);
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0);
        // single event
        add(1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) add(0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0);
        // back-to-back three events
        add(1, 1, 1, 0, 0); add(1, 1, 1, 0, 1); add(1, 1, 1, 0, 2); add(0, 1, 1, 0, 2);
        add(0, 0, 1, 0, 2); add(0, 0, 1, 0, 2);
        cyc(1); cyc(0); add(0, 0, 0, 0, 0);
        // saturation: six events, two dropped
        add(1, 1, 1, 0, 0); add(1, 1, 1, 0, 1); add(1, 1, 1, 0, 2); add(1, 1, 1, 0, 3);
        add(1, 0, 1, 1, 3); add(1, 0, 1, 1, 3);
        cyc(2); cyc(1); cyc(0); add(0, 0, 0, 0, 0);
        // simultaneous consume and queue in the final gap cycle
        add(1, 1, 1, 0, 0); add(1, 1, 1, 0, 1); add(0, 1, 1, 0, 1); add(0, 1, 1, 0, 1);
        add(0, 0, 1, 0, 1); add(0, 0, 1, 0, 1);
        add(1, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 1);
        add(0, 0, 1, 0, 1); add(0, 0, 1, 0, 1);
        cyc(0); add(0, 0, 0, 0, 0);

        reset = 1'b1;
        tick();
        chk("reset", 0, 0, 0, 0);
        reset = 1'b0;

        for (int k = 0; k < v.size(); k++) begin
            In = v[k].in;
            tick();
            chk($sformatf("vec%0d", k), v[k].out, v[k].busy, v[k].drop, v[k].pend);
        end
        In = 1'b0;

        // reset during HOLD with two events queued
        for (int i = 0; i < 3; i++) begin
            In = 1'b1;
            tick();
        end
        chk("pre_reset", 1, 1, 0, 2);
        In = 1'b0;
        reset = 1'b1;
        tick();
        chk("mid_hold_reset", 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("after_reset", 0, 0, 0, 0);
        end

        // loopback: ten spaced events must give ten detected key edges
        begin
            int start_edges;
            int seen_drop;
            int budget;
            start_edges = lb_edges;
            seen_drop = 0;
            for (int n = 0; n < 10; n++) begin
                In = 1'b1;
                tick();
                In = 1'b0;
                for (int g = $urandom_range(6, 15); g > 0; g--) begin
                    if (drop) seen_drop++;
                    tick();
                end
            end
            budget = 0;
            while ((busy || s1 || s2) && budget < 100) begin
                tick();
                budget++;
            end
            repeat (3) tick();
            checks++;
            if (budget >= 100) begin
                errors++;
                $display("FAIL loopback_idle got busy=%b want busy=0 within 100 cycles", busy);
            end
            checks++;
            if (lb_edges - start_edges != 10) begin
                errors++;
                $display("FAIL loopback_edges got %0d want 10", lb_edges - start_edges);
            end
            checks++;
            if (seen_drop != 0) begin
                errors++;
                $display("FAIL loopback_drop got %0d drops want 0", seen_drop);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
